// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared constants for the fetch PC generator.
// Chip-enable levels, reset polarity and the OFF/RUN state encoding live here
// so every block that drives instruction memory agrees on them.
package pc_gen_pkg;

    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;
    localparam logic RstEnable   = 1'b1;

    typedef enum logic {
        OFF = 1'b0,
        RUN = 1'b1
    } pc_state_t;

endpackage : pc_gen_pkg

// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator with a single-entry pending branch.
// After reset the PC sits at RESET_VEC with memory disabled, then fetches
// RESET_VEC once and advances by STEP. Redirect priority is flush, stall,
// branch (live or pending), then sequential increment.
// Optional feature: define PC_ALIGN_CHK_EN to reject redirect targets that are
// not STEP-aligned; the PC then advances sequentially and exc_misalign pulses.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned STEP      = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              exc_misalign
);

    localparam logic [ADDR_W-1:0] STEP_VAL   = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STEP - 1);

    pc_state_t         state;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_target;

    logic [ADDR_W-1:0] seq_pc;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_target;
    logic              misaligned;
    logic [ADDR_W-1:0] next_pc;
    logic              next_pend_valid;
    logic [ADDR_W-1:0] next_pend_target;

    // Sequential successor; the add naturally wraps modulo 2^ADDR_W.
    assign seq_pc = pc + STEP_VAL;

    // Pick the redirect source (if any) by priority, and the pending-entry update.
    always_comb begin
        redirect         = 1'b0;
        redirect_target  = seq_pc;
        next_pend_valid  = pend_valid;
        next_pend_target = pend_target;
        if (flush) begin
            redirect        = 1'b1;
            redirect_target = new_pc;
            next_pend_valid = 1'b0;
        end else if (stall) begin
            if (branch_flag) begin
                next_pend_valid  = 1'b1;
                next_pend_target = branch_target;
            end
        end else if (branch_flag) begin
            redirect        = 1'b1;
            redirect_target = branch_target;
            next_pend_valid = 1'b0;
        end else if (pend_valid) begin
            redirect        = 1'b1;
            redirect_target = pend_target;
            next_pend_valid = 1'b0;
        end
    end

`ifdef PC_ALIGN_CHK_EN
    // A redirect with any low log2(STEP) bit set is rejected.
    always_comb begin
        misaligned = redirect && ((redirect_target & ALIGN_MASK) != '0);
    end
`else
    // Without the alignment check every target is accepted as-is.
    always_comb begin
        misaligned = 1'b0;
    end
`endif

    // Next fetch address in RUN: hold on stall, misaligned targets fall back to sequential.
    always_comb begin
        next_pc = seq_pc;
        if (!flush && stall) begin
            next_pc = pc;
        end else if (redirect && !misaligned) begin
            next_pc = redirect_target;
        end
    end

    // State machine plus all registered outputs; OFF ignores every pipeline input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state       <= OFF;
            ce          <= ChipDisable;
            pc          <= RESET_VEC;
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else begin
            case (state)
                OFF: begin
                    state      <= RUN;
                    ce         <= ChipEnable;
                    pc         <= RESET_VEC;
                    pend_valid <= 1'b0;
                end
                RUN: begin
                    ce          <= ChipEnable;
                    pc          <= next_pc;
                    pend_valid  <= next_pend_valid;
                    pend_target <= next_pend_target;
                end
                default: begin
                    state      <= OFF;
                    ce         <= ChipDisable;
                    pc         <= RESET_VEC;
                    pend_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_ALIGN_CHK_EN
    // One-cycle misalignment pulse, timed with the pc update it affected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            exc_misalign <= 1'b0;
        end else begin
            exc_misalign <= (state == RUN) && misaligned;
        end
    end
`else
    assign exc_misalign = 1'b0;
`endif

endmodule : pc_gen

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed self-checking bench for pc_gen at default parameters.
// Inputs change 1ns after a rising edge; outputs are checked at that point.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_target = '0;
    logic        flush = 1'b0;
    logic [31:0] new_pc = '0;
    logic [31:0] pc;
    logic        ce;
    logic        exc_misalign;

    int checkCount = 0;
    int errorCount = 0;

    pc_gen #(
        .ADDR_W   (32),
        .STEP     (4),
        .RESET_VEC(32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_flag  (branch_flag),
        .branch_target(branch_target),
        .flush        (flush),
        .new_pc       (new_pc),
        .pc           (pc),
        .ce           (ce),
        .exc_misalign (exc_misalign)
    );

    // Free-running 100MHz clock.
    always #5 clk = ~clk;

    // Count a comparison and report it if the observed value differs.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then advance to 1ns past the next rising edge.
    task automatic applyStimulus(input logic s, input logic b, input logic [31:0] bt,
                                 input logic f, input logic [31:0] np);
        stall         = s;
        branch_flag   = b;
        branch_target = bt;
        flush         = f;
        new_pc        = np;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state.
        #2;
        checkOutput("rst_ce", 32'(ce), 32'h0);
        checkOutput("rst_pc", pc, 32'h0);
        checkOutput("rst_exc", 32'(exc_misalign), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("off_ce", 32'(ce), 32'h0);
        checkOutput("off_pc", pc, 32'h0);

        // Reset release: RESET_VEC fetched once, then sequential.
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("run_ce", 32'(ce), 32'h1);
        checkOutput("seq0", pc, 32'h0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("seq4", pc, 32'h4);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("seq8", pc, 32'h8);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("seqC", pc, 32'hC);

        // Simple branches.
        applyStimulus(0, 1, 32'h100, 0, 0);
        checkOutput("br_100", pc, 32'h100);
        applyStimulus(0, 1, 32'h2000, 0, 0);
        checkOutput("br_2000", pc, 32'h2000);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("br_2004", pc, 32'h2004);

        // Stall with two branches: newest pending target wins on release.
        applyStimulus(1, 1, 32'h40, 0, 0);
        checkOutput("stall_hold1", pc, 32'h2004);
        applyStimulus(1, 1, 32'h80, 0, 0);
        checkOutput("stall_hold2", pc, 32'h2004);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("stall_hold3", pc, 32'h2004);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("pend_80", pc, 32'h80);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("pend_84", pc, 32'h84);

        // Flush while stalled with a pending branch and a same-cycle branch.
        applyStimulus(1, 1, 32'h80, 0, 0);
        checkOutput("fl_hold", pc, 32'h84);
        applyStimulus(1, 1, 32'h300, 1, 32'h180);
        checkOutput("fl_180", pc, 32'h180);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("fl_184", pc, 32'h184);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("fl_188", pc, 32'h188);

        // Live branch on release beats the pending entry, which is then dropped.
        applyStimulus(1, 1, 32'h400, 0, 0);
        checkOutput("live_hold", pc, 32'h188);
        applyStimulus(0, 1, 32'h500, 0, 0);
        checkOutput("live_500", pc, 32'h500);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("live_504", pc, 32'h504);

        // Wrap at the top of the address space.
        applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFC);
        checkOutput("wrap_top", pc, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("wrap_0", pc, 32'h0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("wrap_4", pc, 32'h4);

        // Misaligned branch target.
        applyStimulus(0, 0, 0, 1, 32'h10);
        checkOutput("mis_base", pc, 32'h10);
        checkOutput("mis_exc0", 32'(exc_misalign), 32'h0);
        applyStimulus(0, 1, 32'h22, 0, 0);
`ifdef PC_ALIGN_CHK_EN
        checkOutput("mis_pc", pc, 32'h14);
        checkOutput("mis_exc", 32'(exc_misalign), 32'h1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("mis_pc_next", pc, 32'h18);
        checkOutput("mis_exc_clr", 32'(exc_misalign), 32'h0);
        applyStimulus(0, 0, 0, 1, 32'h33);
        checkOutput("mis_flush_pc", pc, 32'h1C);
        checkOutput("mis_flush_exc", 32'(exc_misalign), 32'h1);
`else
        checkOutput("mis_pc", pc, 32'h22);
        checkOutput("mis_exc", 32'(exc_misalign), 32'h0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("mis_pc_next", pc, 32'h26);
        checkOutput("mis_exc_clr", 32'(exc_misalign), 32'h0);
`endif

        // Asynchronous reset mid-operation with a pending branch.
        applyStimulus(1, 1, 32'h600, 0, 0);
        rst = 1'b1;
        #1;
        checkOutput("async_ce", 32'(ce), 32'h0);
        checkOutput("async_pc", pc, 32'h0);
        stall       = 1'b0;
        branch_flag = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        // OFF ignores flush/stall/branch on the OFF->RUN edge.
        applyStimulus(1, 1, 32'h900, 1, 32'h700);
        checkOutput("rerun_ce", 32'(ce), 32'h1);
        checkOutput("rerun_pc", pc, 32'h0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("rerun_pc4", pc, 32'h4);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("rerun_pc8", pc, 32'h8);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule : tb_pc_gen
